lbox_seq_unit: RTL
==================

Name: lbox_seq_unit

Overview:
- Sequential, parametrised L-box engine for the Spook/Clyde linear layer.
- Applies the 32-bit L-box to NPAIR word pairs of a state vector, using LANES L-box instances per cycle.
- Takes a full state over a valid/ready input handshake and returns the transformed state over a valid/ready output handshake.
- Sits between the S-box layer and the round-constant addition in the iterative Clyde datapath.

Parameters:
- NPAIR, 2, number of 64-bit (x,y) word pairs in the state; default gives 128-bit Clyde state
- LANES, 1, L-box instances per cycle; NPAIR mod LANES must be 0 (elaboration error otherwise)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  din/inv valid
- in_ready  output  1  unit can accept a state
- din  input  64*NPAIR  state; pair k = din[64k+63:64k], x = upper 32 bits, y = lower 32 bits
- inv  input  1  inverse L-box select; port exists only with LB_INV_EN
- out_valid  output  1  dout valid
- out_ready  input  1  downstream accepts dout
- dout  output  64*NPAIR  transformed state, same packing as din

Behaviour:
- Forward L-box (rotl = rotate left, all arithmetic is 32-bit XOR/rotate):
  - a1=x^rotl(x,12); a2=a1^rotl(a1,3); a3=a2^rotl(x,17); c=a3^rotl(a3,31)
  - b3 is computed the same way from y; d=b3^rotl(b3,31)
  - a=a3^rotl(d,26)^rotl(c,15); b=b3^rotl(c,25)^rotl(d,15)
- FSM states IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, dout=0, pair counter=0.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready loads din into the state register, latches inv, clears the counter, and moves to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, pairs cnt*LANES .. cnt*LANES+LANES-1 are replaced in place by their L-box result; cnt increments.
  - After NPAIR/LANES cycles, move to DONE.
- DONE:
  - out_valid=1 and dout=state register, held stable until out_valid&out_ready.
  - On handshake, move to IDLE; dout keeps its last value.
- Latency: acceptance edge to out_valid high is NPAIR/LANES+1 clock edges (default 3).
- Throughput: one state per NPAIR/LANES+2 cycles with out_ready tied high. No overlap of input and output handshakes.
- in_valid is ignored in BUSY and DONE. din is sampled only on the accept edge and may change afterwards.
- out_ready is ignored when out_valid=0.
- Counter width is clog2(NPAIR/LANES), minimum 1. It resets to 0 on load, so there is no wrap-around hazard.
- When LANES=NPAIR, BUSY lasts exactly one cycle.
- rst_n low at any time, including mid-BUSY or during DONE with out_ready low:
  - immediately forces IDLE, out_valid=0, in_ready=1, dout=0;
  - the partial state is discarded.
- Reset deassertion is assumed synchronised externally; the first accept is possible on the first edge after release.

Optional Feature:
- Macro: LB_INV_EN.
- Defined:
  - adds the inv port, latched on accept;
  - inv=1 applies the inverse L-box to every pair, defined as the unique map with LBinv(LB(x,y))=(x,y);
  - the inverse is implemented as its own XOR/rotate network, one per lane, selected by a mux per lane;
  - timing and handshake are identical to forward mode.
- Undefined:
  - no inv port and no inverse logic;
  - the unit always applies the forward L-box.

Test Plan:
- Reset, then one state with NPAIR=2, LANES=1, din=0 -> dout=0, out_valid rises 3 edges after accept, in_ready=0 while busy.
- Single-pair vector x=0x00000001, y=0x00000000 placed in pair 0, pair 1 = 0 -> dout pair 0 = (0xEC045008, 0x1B0007B0), pair 1 = (0,0).
- Back-pressure: out_ready held low 10 cycles in DONE -> dout stable, out_valid stays 1, in_valid pulses ignored, in_ready=0; the state is released on the first out_ready.
- rst_n asserted mid-BUSY -> next sample shows out_valid=0, in_ready=1, dout=0; a fresh state is processed correctly afterwards.
- LANES=NPAIR=2 build, random din streamed with out_ready=1 -> latency 2 edges; results match the reference model for 1000 states.
- LB_INV_EN build: forward result fed back with inv=1 -> original din recovered bit-exact for 1000 random states; inv=0 gives forward results.

Source files
------------

// File: rtl/lbox_seq_unit.sv
// lbox_seq_unit: sequential Spook/Clyde L-box layer, LANES pairs per cycle; define LB_INV_EN to add the inverse L-box
module lbox_seq_unit #(
  parameter int NPAIR = 2,
  parameter int LANES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [64*NPAIR-1:0] din,
`ifdef LB_INV_EN
  input  logic                inv,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [64*NPAIR-1:0] dout
);
  localparam int NSTEP = NPAIR / LANES;
  localparam int CW = NSTEP > 1 ? $clog2(NSTEP) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [64*NPAIR-1:0] sr, nxt;
  logic [64*LANES-1:0] lin, lout;
  logic last;
`ifdef LB_INV_EN
  logic inv_q;
`endif
  if (NPAIR % LANES != 0) begin : g_bad
    $error("lbox_seq_unit: NPAIR must be a multiple of LANES");
  end
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  function automatic logic [63:0] lb_fwd(input logic [63:0] v);
    logic [31:0] a, b, c, d;
    a = v[63:32] ^ rotl(v[63:32], 12);
    a = a ^ rotl(a, 3) ^ rotl(v[63:32], 17);
    b = v[31:0] ^ rotl(v[31:0], 12);
    b = b ^ rotl(b, 3) ^ rotl(v[31:0], 17);
    c = a ^ rotl(a, 31);
    d = b ^ rotl(b, 31);
    return {a ^ rotl(d, 26) ^ rotl(c, 15), b ^ rotl(c, 25) ^ rotl(d, 15)};
  endfunction
`ifdef LB_INV_EN
  function automatic logic [63:0] lb_inv(input logic [63:0] v);
    logic [31:0] a, b, c, d;
    a = v[63:32] ^ rotl(v[63:32], 25);
    b = v[31:0] ^ rotl(v[31:0], 25);
    c = v[63:32] ^ rotl(a, 31) ^ rotl(a, 20);
    d = v[31:0] ^ rotl(b, 31) ^ rotl(b, 20);
    a = c ^ rotl(c, 31);
    b = d ^ rotl(d, 31);
    c = c ^ rotl(b, 26);
    d = d ^ rotl(a, 25);
    a = a ^ rotl(c, 17);
    b = b ^ rotl(d, 17);
    return {rotl(a, 16), rotl(b, 16)};
  endfunction
`endif
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lin[64*l +: 64] = sr[64*(int'(cnt)*LANES + l) +: 64];
`ifdef LB_INV_EN
    assign lout[64*l +: 64] = inv_q ? lb_inv(lin[64*l +: 64]) : lb_fwd(lin[64*l +: 64]);
`else
    assign lout[64*l +: 64] = lb_fwd(lin[64*l +: 64]);
`endif
  end
  assign last = cnt == CW'(NSTEP - 1);
  // state vector with the current group of pairs replaced by their L-box result
  always_comb begin
    nxt = sr;
    for (int l = 0; l < LANES; l++) nxt[64*(int'(cnt)*LANES + l) +: 64] = lout[64*l +: 64];
  end
  // load / process / hand off; dout is captured only on entry to DONE so it holds afterwards
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      dout <= '0;
      sr <= '0;
      cnt <= '0;
`ifdef LB_INV_EN
      inv_q <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (in_valid) begin
          sr <= din;
          cnt <= '0;
          in_ready <= 1'b0;
          state <= BUSY;
`ifdef LB_INV_EN
          inv_q <= inv;
`endif
        end
        BUSY: begin
          sr <= nxt;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            dout <= nxt;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
